// File: rtl/ahb_upsizer_32to128.sv
// AHB-Lite 32->128 upsizing bridge in front of a 128-bit zero-wait RAM; AHB_UPSIZER_LINEBUF_EN adds a 128-bit read line buffer.
// Latency: zero added cycles. The address phase is a combinational pass-through and read lanes are muxed in the data phase.
// Backpressure: HREADYOUTS follows HREADYOUTM during forwarded data phases. Illegal sizes get a local two-cycle ERROR.
module ahb_upsizer_32to128 #(
   parameter int ADDRESSWIDTH = 18
) (
   input  logic                    HCLK,
   input  logic                    HRESET,
   input  logic                    HSELS,
   input  logic                    HREADYS,
   input  logic [1:0]              HTRANSS,
   input  logic [2:0]              HSIZES,
   input  logic                    HWRITES,
   input  logic [ADDRESSWIDTH-1:0] HADDRS,
   input  logic [31:0]             HWDATAS,
   output logic                    HREADYOUTS,
   output logic                    HRESPS,
   output logic [31:0]             HRDATAS,
   output logic                    HSELM,
   output logic [1:0]              HTRANSM,
   output logic [2:0]              HSIZEM,
   output logic                    HWRITEM,
   output logic [ADDRESSWIDTH-1:0] HADDRM,
   output logic [127:0]            HWDATAM,
   output logic                    HREADYM,
   input  logic                    HREADYOUTM,
   input  logic                    HRESPM,
   input  logic [127:0]            HRDATAM
);
   localparam int AW = ADDRESSWIDTH;
   localparam logic [1:0] TRN_IDLE = 2'b00;

   typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} err_state_t;

   err_state_t    err_state;
   logic          dp_fwd;
   logic          dp_hit;
   logic          dp_write;
   logic [2:0]    dp_size;
   logic [AW-1:0] dp_addr;

   logic          trn_valid;
   logic          size_ok;
   logic          hit;
   logic          fwd;
   logic [127:0]  rd_line;
   logic [31:0]   rd_lane;

   assign trn_valid = HSELS & HREADYS & HTRANSS[1];
   assign size_ok   = (HSIZES <= 3'd2);
   assign fwd       = trn_valid & size_ok & ~hit & ~HRESET;

   assign HTRANSM = fwd ? HTRANSS : TRN_IDLE;
   assign HSELM   = HTRANSM[1];
   assign HADDRM  = HADDRS;
   assign HSIZEM  = HSIZES;
   assign HWRITEM = HWRITES;
   assign HWDATAM = {4{HWDATAS}};
   assign HREADYM = HREADYOUTS;

   always_comb begin
      HREADYOUTS = 1'b1;
      HRESPS     = 1'b0;
      case (err_state)
         ST_ERR1: begin
            HREADYOUTS = 1'b0;
            HRESPS     = 1'b1;
         end
         ST_ERR2: HRESPS = 1'b1;
         default: begin
            if (dp_fwd) begin
               HREADYOUTS = HREADYOUTM;
               HRESPS     = HRESPM;
            end
         end
      endcase
   end

   always_comb begin
      rd_lane = rd_line[31:0];
      case (dp_addr[3:2])
         2'd1:    rd_lane = rd_line[63:32];
         2'd2:    rd_lane = rd_line[95:64];
         2'd3:    rd_lane = rd_line[127:96];
         default: rd_lane = rd_line[31:0];
      endcase
      HRDATAS = ((dp_fwd | dp_hit) & ~dp_write) ? rd_lane : 32'h0;
   end

   // Data-phase state only advances when the upstream data phase completes; ERR2 accepts a new address.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         err_state <= ST_OKAY;
         dp_fwd    <= 1'b0;
         dp_hit    <= 1'b0;
         dp_write  <= 1'b0;
         dp_size   <= 3'd0;
         dp_addr   <= '0;
      end else if (HREADYOUTS) begin
         dp_fwd    <= fwd;
         dp_hit    <= hit;
         dp_write  <= HWRITES;
         dp_size   <= HSIZES;
         dp_addr   <= HADDRS;
         err_state <= (trn_valid & ~size_ok) ? ST_ERR1 : ST_OKAY;
      end else if (err_state == ST_ERR1) begin
         err_state <= ST_ERR2;
      end
   end

`ifdef AHB_UPSIZER_LINEBUF_EN
   logic [127:0]  linebuf;
   logic [AW-5:0] lb_tag;
   logic          lb_valid;
   logic          dp_done_ok;
   logic [15:0]   wr_be;
   logic [127:0]  wr_merge;

   assign hit        = lb_valid & trn_valid & ~HWRITES & size_ok & (lb_tag == HADDRS[AW-1:4]);
   assign dp_done_ok = dp_fwd & HREADYOUTM & ~HRESPM;
   assign rd_line    = dp_hit ? linebuf : HRDATAM;

   always_comb begin
      case (dp_size)
         3'd0:    wr_be = 16'h0001 << dp_addr[3:0];
         3'd1:    wr_be = 16'h0003 << {dp_addr[3:1], 1'b0};
         default: wr_be = 16'h000F << {dp_addr[3:2], 2'b00};
      endcase
      wr_merge = linebuf;
      for (int i = 0; i < 16; i++) begin
         if (wr_be[i]) wr_merge[8*i +: 8] = HWDATAM[8*i +: 8];
      end
   end

   // Writes to the buffered line are merged so a later hit never returns stale data.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         linebuf  <= '0;
         lb_tag   <= '0;
         lb_valid <= 1'b0;
      end else if (dp_done_ok & ~dp_write) begin
         linebuf  <= HRDATAM;
         lb_tag   <= dp_addr[AW-1:4];
         lb_valid <= 1'b1;
      end else if (dp_done_ok & dp_write & lb_valid & (lb_tag == dp_addr[AW-1:4])) begin
         linebuf  <= wr_merge;
      end
   end
`else
   logic unused_dp_bits;

   assign hit            = 1'b0;
   assign rd_line        = HRDATAM;
   assign unused_dp_bits = ^{dp_size, dp_addr[AW-1:4], dp_addr[1:0]};
`endif

endmodule

// File: tb/tb_ahb_upsizer_32to128.sv
// Bench for ahb_upsizer_32to128: upstream master tasks, a 128-bit RAM responder model and a read-data scoreboard.
module tb_ahb_upsizer_32to128;
   localparam int AW = 18;
`ifdef AHB_UPSIZER_LINEBUF_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic           HSELS;
   logic           HREADYS;
   logic [1:0]     HTRANSS;
   logic [2:0]     HSIZES;
   logic           HWRITES;
   logic [AW-1:0]  HADDRS;
   logic [31:0]    HWDATAS;
   logic           HREADYOUTS;
   logic           HRESPS;
   logic [31:0]    HRDATAS;
   logic           HSELM;
   logic [1:0]     HTRANSM;
   logic [2:0]     HSIZEM;
   logic           HWRITEM;
   logic [AW-1:0]  HADDRM;
   logic [127:0]   HWDATAM;
   logic           HREADYM;
   logic           HREADYOUTM;
   logic           HRESPM;
   logic [127:0]   HRDATAM;

   int checks = 0;
   int errors = 0;

   logic [31:0]  ref_word [0:255];
   logic [127:0] ds_mem [0:63];
   logic [31:0]  exp_q [$];

   int  cfg_wait = 0;
   bit  cfg_err = 1'b0;
   int  fwd_count = 0;

   assign HREADYS = HREADYOUTS;

   ahb_upsizer_32to128 #(.ADDRESSWIDTH(AW)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HSELS(HSELS), .HREADYS(HREADYS), .HTRANSS(HTRANSS), .HSIZES(HSIZES),
      .HWRITES(HWRITES), .HADDRS(HADDRS), .HWDATAS(HWDATAS),
      .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS), .HRDATAS(HRDATAS),
      .HSELM(HSELM), .HTRANSM(HTRANSM), .HSIZEM(HSIZEM), .HWRITEM(HWRITEM),
      .HADDRM(HADDRM), .HWDATAM(HWDATAM), .HREADYM(HREADYM),
      .HREADYOUTM(HREADYOUTM), .HRESPM(HRESPM), .HRDATAM(HRDATAM)
   );

   always #5 HCLK = ~HCLK;

   // Downstream RAM: samples at negedge, acts just after posedge; optional wait states and two-cycle ERROR.
   initial begin : ds_model
      bit           ds_pend, ds_wr, ds_err, ds_errp;
      int           ds_cnt, base;
      logic [AW-1:0] ds_addr;
      logic [2:0]   ds_size;
      bit           s_ap, s_wr, s_rdy, s_resp, s_rst;
      logic [AW-1:0] s_addr;
      logic [2:0]   s_size;
      logic [127:0] s_wdat, line;
      ds_pend = 0; ds_wr = 0; ds_err = 0; ds_errp = 0; ds_cnt = 0;
      ds_addr = '0; ds_size = 3'd0;
      for (int l = 0; l < 64; l++)
         for (int w = 0; w < 4; w++) ds_mem[l][32*w +: 32] = 32'hC0DE_0000 | 32'(l*16 + w*4);
      HREADYOUTM = 1'b1; HRESPM = 1'b0; HRDATAM = '0;
      forever begin
         @(negedge HCLK);
         s_ap = HSELM & HTRANSM[1] & HREADYM;
         s_addr = HADDRM; s_wr = HWRITEM; s_size = HSIZEM; s_wdat = HWDATAM;
         s_rdy = HREADYOUTM; s_resp = HRESPM; s_rst = HRESET;
         @(posedge HCLK); #1;
         if (s_rst) ds_pend = 0;
         else begin
            if (ds_pend && s_rdy) begin
               if (ds_wr && !s_resp) begin
                  line = ds_mem[ds_addr[9:4]];
                  base = int'(ds_addr[3:0]);
                  for (int k = 0; k < (1 << ds_size); k++) line[8*(base+k) +: 8] = s_wdat[8*(base+k) +: 8];
                  ds_mem[ds_addr[9:4]] = line;
               end
               ds_pend = 0;
            end
            if (s_ap) begin
               ds_pend = 1; ds_addr = s_addr; ds_wr = s_wr; ds_size = s_size;
               ds_cnt = cfg_wait; ds_err = cfg_err; ds_errp = 0;
               fwd_count++;
            end
         end
         if (!ds_pend) begin HREADYOUTM = 1'b1; HRESPM = 1'b0; end
         else if (ds_cnt > 0) begin HREADYOUTM = 1'b0; HRESPM = 1'b0; ds_cnt--; end
         else if (ds_err && !ds_errp) begin HREADYOUTM = 1'b0; HRESPM = 1'b1; ds_errp = 1; end
         else begin HREADYOUTM = 1'b1; HRESPM = ds_err; end
         HRDATAM = ds_pend ? ds_mem[ds_addr[9:4]] : '0;
      end
   end

   task automatic do_xfer(input string nm, input bit wr, input logic [2:0] sz, input logic [AW-1:0] a,
                          input logic [31:0] wd, input bit exp_fwd, input int exp_low, input bit exp_err);
      int n_low;
      bit done;
      logic [31:0] want, w;
      HSELS = 1'b1; HTRANSS = 2'b10; HSIZES = sz; HWRITES = wr; HADDRS = a;
      if (!wr && !exp_err) exp_q.push_back(ref_word[a[9:2]]);
      @(negedge HCLK);
      checks++;
      if (HTRANSM !== (exp_fwd ? 2'b10 : 2'b00)) begin
         errors++; $display("FAIL %s htransm: got %0h want %0h", nm, HTRANSM, exp_fwd ? 2'b10 : 2'b00);
      end
      if (exp_fwd) begin
         checks++;
         if (HADDRM !== a) begin errors++; $display("FAIL %s haddrm: got %0h want %0h", nm, HADDRM, a); end
      end
      @(posedge HCLK); #1;
      HSELS = 1'b0; HTRANSS = 2'b00; HWDATAS = wd;
      n_low = 0; done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge HCLK);
         if (HREADYOUTS === 1'b1) done = 1;
         else begin
            n_low++;
            if (exp_err) begin
               checks++;
               if (HRESPS !== 1'b1) begin errors++; $display("FAIL %s hresps_low: got %b want 1", nm, HRESPS); end
            end
            @(posedge HCLK); #1;
         end
      end
      checks++;
      if (!done) begin errors++; $display("FAIL %s timeout: HREADYOUTS never high", nm); end
      checks++;
      if (n_low != exp_low) begin errors++; $display("FAIL %s wait_cycles: got %0d want %0d", nm, n_low, exp_low); end
      checks++;
      if (HRESPS !== exp_err) begin errors++; $display("FAIL %s hresps: got %b want %b", nm, HRESPS, exp_err); end
      if (wr) begin
         checks++;
         if (HWDATAM !== {4{wd}}) begin errors++; $display("FAIL %s hwdatam: got %h want %h", nm, HWDATAM, {4{wd}}); end
      end
      if (!wr && !exp_err) begin
         want = exp_q.pop_front();
         checks++;
         if (HRDATAS !== want) begin errors++; $display("FAIL %s hrdatas: got %h want %h", nm, HRDATAS, want); end
      end
      @(posedge HCLK); #1;
      if (wr && !exp_err && done) begin
         w = ref_word[a[9:2]];
         for (int b = int'(a[1:0]); b < int'(a[1:0]) + (1 << sz); b++) w[8*b +: 8] = wd[8*b +: 8];
         ref_word[a[9:2]] = w;
      end
   endtask

   task automatic test_reset;
      HRESET = 1'b1; HSELS = 1'b1; HTRANSS = 2'b10; HSIZES = 3'd2; HWRITES = 1'b0;
      HADDRS = 18'h10; HWDATAS = '0;
      repeat (2) @(posedge HCLK);
      @(negedge HCLK);
      checks++;
      if (HTRANSM !== 2'b00 || HSELM !== 1'b0) begin
         errors++; $display("FAIL reset_htransm: got %0h/%b want 0/0", HTRANSM, HSELM);
      end
      checks++;
      if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b0 || HRDATAS !== 32'h0) begin
         errors++; $display("FAIL reset_outs: got rdy=%b resp=%b rd=%h want 1/0/0", HREADYOUTS, HRESPS, HRDATAS);
      end
      @(posedge HCLK); #1;
      HRESET = 1'b0; HSELS = 1'b0; HTRANSS = 2'b00;
      @(negedge HCLK);
      checks++;
      if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b0 || HRDATAS !== 32'h0) begin
         errors++; $display("FAIL post_reset_outs: got rdy=%b resp=%b rd=%h want 1/0/0", HREADYOUTS, HRESPS, HRDATAS);
      end
      @(posedge HCLK); #1;
   endtask

   task automatic test_word;
      do_xfer("wr14", 1'b1, 3'd2, 18'h14, 32'hDEADBEEF, 1'b1, 0, 1'b0);
      do_xfer("rd14", 1'b0, 3'd2, 18'h14, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_byte;
      do_xfer("wrb23", 1'b1, 3'd0, 18'h23, 32'hA500_0000, 1'b1, 0, 1'b0);
      do_xfer("rdh22", 1'b0, 3'd1, 18'h22, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_size_err;
      int f0;
      f0 = fwd_count;
      do_xfer("sz3_30", 1'b0, 3'd3, 18'h30, 32'h0, 1'b0, 1, 1'b1);
      @(negedge HCLK);
      checks++;
      if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b0) begin
         errors++; $display("FAIL sz3_after: got rdy=%b resp=%b want 1/0", HREADYOUTS, HRESPS);
      end
      checks++;
      if (fwd_count != f0) begin errors++; $display("FAIL sz3_fwd: got %0d forwards want 0", fwd_count - f0); end
      @(posedge HCLK); #1;
   endtask

   task automatic test_wait_err;
      cfg_wait = 2;
      do_xfer("wait_rd50", 1'b0, 3'd2, 18'h50, 32'h0, 1'b1, 2, 1'b0);
      cfg_wait = 0; cfg_err = 1'b1;
      do_xfer("derr_rd60", 1'b0, 3'd2, 18'h60, 32'h0, 1'b1, 1, 1'b1);
      cfg_err = 1'b0;
      do_xfer("nofill_rd64", 1'b0, 3'd2, 18'h64, 32'h0, 1'b1, 0, 1'b0);
   endtask

   task automatic test_linebuf;
      int f0;
      f0 = fwd_count;
      do_xfer("lb_rd40", 1'b0, 3'd2, 18'h40, 32'h0, 1'b1, 0, 1'b0);
      do_xfer("lb_rd44", 1'b0, 3'd2, 18'h44, 32'h0, !LB, 0, 1'b0);
      do_xfer("lb_rd48", 1'b0, 3'd2, 18'h48, 32'h0, !LB, 0, 1'b0);
      do_xfer("lb_rd4c", 1'b0, 3'd2, 18'h4C, 32'h0, !LB, 0, 1'b0);
      checks++;
      if (fwd_count - f0 != (LB ? 1 : 4)) begin
         errors++; $display("FAIL lb_fwd_count: got %0d want %0d", fwd_count - f0, LB ? 1 : 4);
      end
      do_xfer("lb_wr48", 1'b1, 3'd2, 18'h48, 32'h12345678, 1'b1, 0, 1'b0);
      do_xfer("lb_rd48b", 1'b0, 3'd2, 18'h48, 32'h0, !LB, 0, 1'b0);
   endtask

   task automatic test_reset_mid;
      cfg_wait = 3;
      HSELS = 1'b1; HTRANSS = 2'b10; HSIZES = 3'd2; HWRITES = 1'b0; HADDRS = 18'h70;
      @(negedge HCLK);
      checks++;
      if (HTRANSM !== 2'b10) begin errors++; $display("FAIL rstmid_fwd: got %0h want 2", HTRANSM); end
      @(posedge HCLK); #1;
      HSELS = 1'b0; HTRANSS = 2'b00;
      @(negedge HCLK);
      checks++;
      if (HREADYOUTS !== 1'b0) begin errors++; $display("FAIL rstmid_wait: got %b want 0", HREADYOUTS); end
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      @(posedge HCLK); #1;
      HRESET = 1'b0; cfg_wait = 0;
      @(negedge HCLK);
      checks++;
      if (HREADYOUTS !== 1'b1 || HRESPS !== 1'b0 || HRDATAS !== 32'h0) begin
         errors++; $display("FAIL rstmid_outs: got rdy=%b resp=%b rd=%h want 1/0/0", HREADYOUTS, HRESPS, HRDATAS);
      end
      @(posedge HCLK); #1;
      do_xfer("rstmid_rd44", 1'b0, 3'd2, 18'h44, 32'h0, 1'b1, 0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_word[i] = 32'hC0DE_0000 | 32'(i*4);
      test_reset();
      test_word();
      test_byte();
      test_size_err();
      test_wait_err();
      test_linebuf();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
